// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU controller and its alu1 slice.
package alu_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // alu1 slice control codes
    localparam logic [2:0] OP_ADD = 3'd2;  // a + b + cin
    localparam logic [2:0] OP_SUB = 3'd3;  // a + ~b + cin
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOR = 3'd7;

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bus between a requester and the serial ALU controller.
interface alu_serial_ctrl_if #(parameter int unsigned WIDTH = 8);

    logic             start;
    logic             abort;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, abort, op, a, b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, abort, op, a, b, cin,
        output busy, done, result, cout
    );

endinterface

// File: rtl/alu1.sv
// One-bit ALU slice; purely combinational.
module alu1
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] ctrl,
    output logic       y,
    output logic       cout
);

    // Bit result and carry for the selected operation; logic ops produce no carry
    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        case (ctrl)
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = (a & b) | (cin & (a ^ b));
            end
            OP_SUB: begin
                y    = a ^ ~b ^ cin;
                cout = (a & ~b) | (cin & (a ^ ~b));
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            default: begin
                y    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_top.sv
// Serial controller wired to its alu1 slice.
module alu_serial_top #(
    parameter int unsigned WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    alu_serial_ctrl_if.slave bus
);

    logic       alu_a;
    logic       alu_b;
    logic       alu_cin;
    logic [2:0] alu_ctrl;
    logic       alu_out;
    logic       alu_cout;

    alu_serial_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
    );

    alu1 u_slice (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (alu_cin),
        .ctrl (alu_ctrl),
        .y    (alu_out),
        .cout (alu_cout)
    );

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial controller: feeds an external one-bit slice LSB first and assembles the result.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    alu_serial_ctrl_if.slave  bus,
    output logic              alu_a,
    output logic              alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_ctrl,
    input  logic              alu_out,
    input  logic              alu_cout
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;

    // abort takes priority over start in IDLE
    assign accept   = (state == IDLE) && bus.start && !bus.abort;
    assign last_bit = (cnt == LAST);

    assign bus.result = result_q;
    assign bus.cout   = cout_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, status flags, slice drive and shift-register update
    always_comb begin
        state_nxt = state;
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cin   = 1'b0;
        alu_ctrl  = '0;
        shift_nxt = shift_q;
        shift_nxt[cnt] = alu_out;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                alu_a    = a_q[cnt];
                alu_b    = b_q[cnt];
                alu_cin  = carry_q;
                alu_ctrl = op_q;
                if (bus.abort)     state_nxt = IDLE;
                else if (last_bit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch at accept, per-bit capture in RUN, result commit on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            shift_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            carry_q <= bus.cin;
            cnt     <= '0;
        end else if (state == RUN && !bus.abort) begin
            shift_q <= shift_nxt;
            carry_q <= alu_cout;
            if (last_bit) begin
                result_q <= shift_nxt;
                cout_q   <= alu_cout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl driving an alu1 slice; a wrapped alu_serial_top runs alongside.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [2:0] op;
        logic [7:0] res;
        logic       co;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_a;
    logic       alu_b;
    logic       alu_cin;
    logic [2:0] alu_ctrl;
    logic       alu_out;
    logic       alu_cout;

    int total = 0;
    int bad   = 0;

    alu_serial_ctrl_if #(.WIDTH(8)) bus ();
    alu_serial_ctrl_if #(.WIDTH(8)) bus_top ();

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
    );

    alu1 u_slice (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (alu_cin),
        .ctrl (alu_ctrl),
        .y    (alu_out),
        .cout (alu_cout)
    );

    alu_serial_top #(.WIDTH(8)) u_top (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_top)
    );

    assign bus_top.start = bus.start;
    assign bus_top.abort = bus.abort;
    assign bus_top.op    = bus.op;
    assign bus_top.a     = bus.a;
    assign bus_top.b     = bus.b;
    assign bus_top.cin   = bus.cin;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE, returns at a negedge in IDLE one cycle after done
    task automatic run_op(input vec_t v, input string tag);
        int done_cyc;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.cin   = v.cin;
        bus.op    = v.op;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        done_cyc  = 0;
        for (int n = 1; n <= 20 && done_cyc == 0; n++) begin
            if (n <= 8) begin
                check({tag, " alu_a"}, 32'(alu_a), 32'(v.a[n-1]));
                check({tag, " alu_b"}, 32'(alu_b), 32'(v.b[n-1]));
            end
            if (n == 1) begin
                check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(v.op));
                check({tag, " alu_cin"},  32'(alu_cin),  32'(v.cin));
            end
            if (bus.done) done_cyc = n;
            else          @(negedge clk);
        end
        check({tag, " done_cycle"}, 32'(done_cyc), 32'd9);
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd1);
        check({tag, " result"}, 32'(bus.result), 32'(v.res));
        check({tag, " cout"}, 32'(bus.cout), 32'(v.co));
        check({tag, " top_result"}, 32'(bus_top.result), 32'(v.res));
        check({tag, " top_cout"}, 32'(bus_top.cout), 32'(v.co));
        @(negedge clk);
        check({tag, " done_after"}, 32'(bus.done), 32'd0);
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, " alu_ctrl_idle"}, 32'(alu_ctrl), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   ndone;
        int   first_d;
        int   second_d;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, OP_ADD, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, OP_ADD, 8'h01, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, OP_ADD, 8'h01, 1'b1};
        vecs[4] = '{8'h10, 8'h01, 1'b1, OP_SUB, 8'h0F, 1'b1};
        vecs[5] = '{8'hF0, 8'h3C, 1'b0, OP_AND, 8'h30, 1'b0};
        vecs[6] = '{8'hA0, 8'h05, 1'b0, OP_OR,  8'hA5, 1'b0};
        vecs[7] = '{8'hFF, 8'h0F, 1'b0, OP_XOR, 8'hF0, 1'b0};
        vecs[8] = '{8'h0F, 8'h30, 1'b0, OP_NOR, 8'hC0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        @(negedge clk);
        check("rst busy",   32'(bus.busy),   32'd0);
        check("rst done",   32'(bus.done),   32'd0);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst cout",   32'(bus.cout),   32'd0);
        check("rst alu_a",  32'(alu_a),      32'd0);
        check("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);

        // first vector starts on the first edge after release
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start held high: one done at cycle 9, re-accept at edge 10 with new operands
        bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; bus.op = OP_ADD; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h01;
        ndone = 0; first_d = 0; second_d = 0;
        for (int n = 1; n <= 24; n++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1)      first_d  = n;
                else if (ndone == 2) second_d = n;
            end
            if (n == 9)  check("hold result1", 32'(bus.result), 32'h8D);
            if (n == 10) check("hold busy_idle", 32'(bus.busy), 32'd0);
            if (n == 11) begin
                check("hold busy_reaccept", 32'(bus.busy), 32'd1);
                bus.start = 1'b0;
            end
            if (n == 19) begin
                check("hold result2", 32'(bus.result), 32'h00);
                check("hold cout2",   32'(bus.cout),   32'd1);
            end
            @(negedge clk);
        end
        check("hold done_count", 32'(ndone),    32'd2);
        check("hold done1_cyc",  32'(first_d),  32'd9);
        check("hold done2_cyc",  32'(second_d), 32'd19);

        // abort in RUN cycle 4 after a completed 5A+33
        run_op(vecs[0], "pre_abort");
        bus.a = 8'hFF; bus.b = 8'h01; bus.cin = 1'b0; bus.op = OP_ADD; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort alu_ctrl", 32'(alu_ctrl), 32'd0);
        ndone = 0;
        for (int n = 5; n <= 14; n++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check("abort no_done", 32'(ndone), 32'd0);
        check("abort result", 32'(bus.result), 32'h8D);
        check("abort cout",   32'(bus.cout),   32'd0);

        // abort and start together in IDLE: no accept
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_start busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);

        // reset mid-RUN clears outputs before the next edge
        bus.a = 8'hFF; bus.b = 8'h01; bus.cin = 1'b0; bus.op = OP_ADD; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst pre_busy", 32'(bus.busy), 32'd1);
        check("midrst pre_ctrl", 32'(alu_ctrl), 32'(OP_ADD));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy",     32'(bus.busy),   32'd0);
        check("midrst done",     32'(bus.done),   32'd0);
        check("midrst result",   32'(bus.result), 32'd0);
        check("midrst cout",     32'(bus.cout),   32'd0);
        check("midrst alu_a",    32'(alu_a),      32'd0);
        check("midrst alu_b",    32'(alu_b),      32'd0);
        check("midrst alu_cin",  32'(alu_cin),    32'd0);
        check("midrst alu_ctrl", 32'(alu_ctrl),   32'd0);
        check("midrst top_result", 32'(bus_top.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a WIDTH-bit operation; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 op  input  3  slice control code, latched at accept, driven unchanged on alu_ctrl.
REQ-007 a, b  input  WIDTH  operands, latched at accept.
REQ-008 cin  input  1  carry into bit 0, latched at accept.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  WIDTH  last completed result.
REQ-012 cout  output  1  carry out of bit WIDTH-1 of last completed operation.
REQ-013 alu_a, alu_b, alu_cin  output  1 each  bit operands and carry to the external alu1 slice.
REQ-014 alu_ctrl  output  3  control code to the slice.
REQ-015 alu_out, alu_cout  input  1 each  slice result and carry, combinational from the slice inputs.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE & start=1 -> RUN; latch a, b, op, cin; bit counter = 0.
REQ-018 RUN, bit index i = 0..WIDTH-1, LSB first: alu_a=a[i], alu_b=b[i], alu_cin=carry register (cin when i=0, else alu_cout from bit i-1), alu_ctrl=op.
REQ-019 Each RUN cycle: capture alu_out into bit i of an internal shift register; carry register <= alu_cout; counter increments.
REQ-020 RUN with counter = WIDTH-1 -> DONE; result <= completed shift register; cout <= alu_cout of bit WIDTH-1.
REQ-021 DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-022 Latency: start accepted at edge 0; done high in cycle WIDTH+1; next start accepted at earliest edge WIDTH+2.
REQ-023 start in RUN or DONE: ignored, no queuing.
REQ-024 abort=1 in RUN -> IDLE next edge; no done; result and cout unchanged. abort in IDLE/DONE: no effect. abort and start together in IDLE: abort wins, no accept.
REQ-025 result/cout change only on RUN->DONE; stable otherwise.
REQ-026 Slice outputs alu_a, alu_b, alu_cin, alu_ctrl = 0 in IDLE and DONE.
REQ-027 Counter width ceil(log2(WIDTH)); no wrap beyond WIDTH-1.

Reset
REQ-028 rst_n low at any time, including mid-RUN: state IDLE, busy=0, done=0, result=0, cout=0, all alu_* outputs 0, counter and carry 0, latched operands 0.
REQ-029 Release of rst_n needs no start hold-off; start on first edge after release is accepted.

Structure
REQ-030 Package alu_pkg holds the state enum (IDLE, RUN, DONE) and opcode constants (OP_ADD = 3'd2 and the remaining alu1 codes 3..7).
REQ-031 No sub-module inside alu_serial_ctrl; the alu1 slice is instantiated beside it in alu_serial_top, which wires alu_* ports.

Verification (bench: alu_serial_top, WIDTH=8, alu1 control 2 = full add with carry)
REQ-032 Add: a=8'h5A, b=8'h33, cin=0, op=2 -> done in cycle 9 after accept, result=8'h8D, cout=0.
REQ-033 Wrap: a=8'hFF, b=8'h01, cin=0, op=2 -> result=8'h00, cout=1.
REQ-034 Carry-in: a=8'h00, b=8'h00, cin=1, op=2 -> result=8'h01, cout=0.
REQ-035 start held high through RUN and DONE after REQ-032 -> single done pulse; second accept at edge 10; the op following done is accepted only from IDLE.
REQ-036 abort at RUN cycle 4 after REQ-032 completed -> no done, busy low next cycle, result stays 8'h8D.
REQ-037 rst_n low mid-RUN -> all outputs 0 asynchronously, before the next clock edge; after release, fresh add matches REQ-032.
